// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
// Bundles the two producer handshakes (ALU, LSU load return) and the
// register-file write port of the writeback arbiter.
//   alu_valid/alu_rd/alu_data -> alu_ready : ALU result handshake
//   lsu_valid/lsu_rd/lsu_data -> lsu_ready : load result handshake (into FIFO)
//   reg_write/write_reg/write_data         : registered register-file write port
//   fifo_count, busy                       : status
// The slave modport is the arbiter; the master modport is the producer/consumer side.
interface writeback_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic [4:0]               alu_rd;
  logic [XLEN-1:0]          alu_data;
  logic                     alu_ready;
  logic                     lsu_valid;
  logic [4:0]               lsu_rd;
  logic [XLEN-1:0]          lsu_data;
  logic                     lsu_ready;
  logic                     reg_write;
  logic [4:0]               write_reg;
  logic [XLEN-1:0]          write_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, reg_write, write_reg, write_data,
           fifo_count, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, reg_write, write_reg, write_data,
           fifo_count, busy
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Drives the single register-file write port from the ALU path and a small
// FIFO of load results. The ALU wins by default; a starvation counter forces
// the FIFO head through after STARVE_LIMIT consecutive ALU grants that blocked it.
// Writes to x0 are accepted but never asserted on reg_write.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : writeback_arbiter_if.slave (handshakes, write port, status)
module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_arbiter_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_ALU  = 2'd1;
  localparam logic [1:0] GRANT_FIFO = 2'd2;

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [SW-1:0]   starve_cnt;

  logic            fifo_nonempty;
  logic            force_pop;
  logic [1:0]      grant_sel;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            push;
  logic            pop;

  // Readiness depends only on registered state so producers never see a
  // combinational loop through their own valid.
  assign fifo_nonempty  = (count != '0);
  assign force_pop      = (starve_cnt == STARVE_MAX) && fifo_nonempty;
  assign bus.alu_ready  = !force_pop;
  assign bus.lsu_ready  = (count < FULL_COUNT);
  assign push           = bus.lsu_valid && bus.lsu_ready;
  assign pop            = (grant_sel == GRANT_FIFO);

  always_comb begin
    grant_sel = GRANT_NONE;
    sel_rd    = '0;
    sel_data  = '0;
    if (force_pop) begin
      grant_sel = GRANT_FIFO;
    end else if (bus.alu_valid) begin
      grant_sel = GRANT_ALU;
    end else if (fifo_nonempty) begin
      grant_sel = GRANT_FIFO;
    end
    case (grant_sel)
      GRANT_ALU: begin
        sel_rd   = bus.alu_rd;
        sel_data = bus.alu_data;
      end
      GRANT_FIFO: begin
        sel_rd   = fifo_rd[rd_ptr];
        sel_data = fifo_data[rd_ptr];
      end
      default: begin
        sel_rd   = '0;
        sel_data = '0;
      end
    endcase
  end

  // Storage needs no reset: only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lsu_rd;
      fifo_data[wr_ptr] <= bus.lsu_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counts ALU grants that blocked a waiting head; any pop or empty FIFO restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || !fifo_nonempty) begin
      starve_cnt <= '0;
    end else if ((grant_sel == GRANT_ALU) && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // An x0 grant still updates address/data but never raises the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.reg_write  <= 1'b0;
      bus.write_reg  <= '0;
      bus.write_data <= '0;
    end else if (grant_sel != GRANT_NONE) begin
      bus.reg_write  <= (sel_rd != 5'd0);
      bus.write_reg  <= sel_rd;
      bus.write_data <= sel_data;
    end else begin
      bus.reg_write  <= 1'b0;
    end
  end

  assign bus.fifo_count = count;
  assign bus.busy       = fifo_nonempty || bus.reg_write;
endmodule
